// File: rtl/arb_rr_bin_if.sv
// Grant-side bundle of the round-robin arbiter: request vector in,
// binary grant index out, with a valid/ready handshake.
interface arb_rr_bin_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned WIDTH_LOG = $clog2(WIDTH);

  logic [WIDTH-1:0]     req;
  logic                 rdy;
  logic                 vld;
  logic [WIDTH_LOG-1:0] bin;

  modport master (
    input  req,
    input  rdy,
    output vld,
    output bin
  );

  modport slave (
    output req,
    output rdy,
    input  vld,
    input  bin
  );
endinterface

// File: rtl/arb_rr_bin.sv
// Registered round-robin arbiter producing a binary grant index.
// The priority pointer advances past each issued grant.
module arb_rr_bin #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned IMPLEMENTATION = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  arb_rr_bin_if.master  bus
);
  localparam int unsigned WIDTH_LOG = $clog2(WIDTH);

  typedef logic [WIDTH_LOG-1:0] idx_t;

  logic vld_r;
  idx_t bin_r;
  idx_t ptr_r;
  idx_t sel;
  logic any;
  logic ld;

  assign any     = |bus.req;
  assign ld      = !vld_r || bus.rdy;
  assign bus.vld = vld_r;
  assign bus.bin = bin_r;

  generate
    if (IMPLEMENTATION == 0) begin : g_loop
      logic        hit;
      int unsigned idx;

      // Scan ptr, ptr+1, ... with wrap at WIDTH; first hit wins.
      always_comb begin
        sel = '0;
        hit = 1'b0;
        idx = 0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
          idx = 32'(ptr_r) + k;
          if (idx >= WIDTH) idx = idx - WIDTH;
          if (!hit && bus.req[idx_t'(idx)]) begin
            hit = 1'b1;
            sel = idx_t'(idx);
          end
        end
      end
    end else if (IMPLEMENTATION == 1) begin : g_mask
      logic [WIDTH-1:0] mask;
      logic [WIDTH-1:0] masked;

      function automatic idx_t first_one(input logic [WIDTH-1:0] v);
        idx_t j;
        first_one = '0;
        // Descending walk so the lowest set bit is the last one written.
        for (int unsigned i = WIDTH; i > 0; i--) begin
          j = idx_t'(i - 1);
          if (v[j]) first_one = j;
        end
      endfunction

      always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
          mask[idx_t'(i)] = (i >= 32'(ptr_r));
        end
        masked = bus.req & mask;
        sel    = (|masked) ? first_one(masked) : first_one(bus.req);
      end
    end else begin : g_bad
      $fatal(1, "arb_rr_bin: IMPLEMENTATION must be 0 or 1");
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_r <= 1'b0;
      bin_r <= '0;
      ptr_r <= '0;
    end else if (ld) begin
      if (any) begin
        vld_r <= 1'b1;
        bin_r <= sel;
        // Wrap at WIDTH, which need not be a power of two.
        ptr_r <= (32'(sel) == WIDTH - 1) ? '0 : idx_t'(sel + 1'b1);
      end else begin
        vld_r <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_arb_rr_bin.sv
// Scoreboard bench for arb_rr_bin: directed vectors push expected grants,
// a monitor pops and compares both search structures at WIDTH=8 and WIDTH=5.
module tb_arb_rr_bin;
  logic       clk;
  logic       rst_n;
  logic       rdy;
  logic [7:0] req8;
  logic [4:0] req5;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is5;
    logic       v;
    logic [2:0] b;
  } exp_t;

  exp_t sb[$];

  arb_rr_bin_if #(.WIDTH(8)) if80 ();
  arb_rr_bin_if #(.WIDTH(8)) if81 ();
  arb_rr_bin_if #(.WIDTH(5)) if50 ();
  arb_rr_bin_if #(.WIDTH(5)) if51 ();

  assign if80.req = req8;
  assign if81.req = req8;
  assign if50.req = req5;
  assign if51.req = req5;
  assign if80.rdy = rdy;
  assign if81.rdy = rdy;
  assign if50.rdy = rdy;
  assign if51.rdy = rdy;

  arb_rr_bin #(.WIDTH(8), .IMPLEMENTATION(0)) u80 (.clk(clk), .rst_n(rst_n), .bus(if80));
  arb_rr_bin #(.WIDTH(8), .IMPLEMENTATION(1)) u81 (.clk(clk), .rst_n(rst_n), .bus(if81));
  arb_rr_bin #(.WIDTH(5), .IMPLEMENTATION(0)) u50 (.clk(clk), .rst_n(rst_n), .bus(if50));
  arb_rr_bin #(.WIDTH(5), .IMPLEMENTATION(1)) u51 (.clk(clk), .rst_n(rst_n), .bus(if51));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got vld,bin=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] q8, input logic [4:0] q5,
                      input logic rd, input logic is5, input logic v, input logic [2:0] b);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    req8  = q8;
    req5  = q5;
    rdy   = rd;
    e.is5 = is5;
    e.v   = v;
    e.b   = b;
    sb.push_back(e);
  endtask

  // Monitor: one expectation per cycle, sampled 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (!e.is5) begin
          chk("w8_impl0", {if80.vld, if80.bin}, {e.v, e.b});
          chk("w8_impl1", {if81.vld, if81.bin}, {e.v, e.b});
        end else begin
          chk("w5_impl0", {if50.vld, if50.bin}, {e.v, e.b});
          chk("w5_impl1", {if51.vld, if51.bin}, {e.v, e.b});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    req8  = 8'hFF;
    req5  = '0;
    rdy   = 1'b1;

    // Reset held with all requests pending
    repeat (3) step(1'b0, 8'hFF, 5'h00, 1'b1, 1'b0, 1'b0, 3'd0);

    // Full request vector: 0..7 then 0,1
    for (int i = 0; i < 8; i++) step(1'b1, 8'hFF, 5'h00, 1'b1, 1'b0, 1'b1, 3'(i));
    step(1'b1, 8'hFF, 5'h00, 1'b1, 1'b0, 1'b1, 3'd0);
    step(1'b1, 8'hFF, 5'h00, 1'b1, 1'b0, 1'b1, 3'd1);

    // Two end requestors alternate (ptr=2 at start)
    step(1'b1, 8'h81, 5'h00, 1'b1, 1'b0, 1'b1, 3'd7);
    step(1'b1, 8'h81, 5'h00, 1'b1, 1'b0, 1'b1, 3'd0);
    step(1'b1, 8'h81, 5'h00, 1'b1, 1'b0, 1'b1, 3'd7);
    step(1'b1, 8'h81, 5'h00, 1'b1, 1'b0, 1'b1, 3'd0);
    step(1'b1, 8'h81, 5'h00, 1'b1, 1'b0, 1'b1, 3'd7);
    // ptr=0 -> 2; ptr=3 -> 4; ptr=5 -> 2 via wrap; ptr=3 -> 3
    step(1'b1, 8'h04, 5'h00, 1'b1, 1'b0, 1'b1, 3'd2);
    step(1'b1, 8'h10, 5'h00, 1'b1, 1'b0, 1'b1, 3'd4);
    step(1'b1, 8'h04, 5'h00, 1'b1, 1'b0, 1'b1, 3'd2);
    step(1'b1, 8'h08, 5'h00, 1'b1, 1'b0, 1'b1, 3'd3);

    // Backpressure: grant 3 held while req toggles, bit 3 dropped
    step(1'b1, 8'hFF, 5'h00, 1'b0, 1'b0, 1'b1, 3'd3);
    step(1'b1, 8'h00, 5'h00, 1'b0, 1'b0, 1'b1, 3'd3);
    step(1'b1, 8'hF7, 5'h00, 1'b0, 1'b0, 1'b1, 3'd3);
    step(1'b1, 8'h01, 5'h00, 1'b0, 1'b0, 1'b1, 3'd3);
    // Release: search resumes at 4
    step(1'b1, 8'h18, 5'h00, 1'b1, 1'b0, 1'b1, 3'd4);
    // No requests: vld drops, bin holds
    step(1'b1, 8'h00, 5'h00, 1'b1, 1'b0, 1'b0, 3'd4);
    step(1'b1, 8'h00, 5'h00, 1'b0, 1'b0, 1'b0, 3'd4);
    // Idle output loads even with rdy=0; then holds
    step(1'b1, 8'h20, 5'h00, 1'b0, 1'b0, 1'b1, 3'd5);
    step(1'b1, 8'h00, 5'h00, 1'b0, 1'b0, 1'b1, 3'd5);

    // Async reset mid-cycle while a grant is stalled
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_impl0", {if80.vld, if80.bin}, 4'b0000);
    chk("async_rst_impl1", {if81.vld, if81.bin}, 4'b0000);
    step(1'b0, 8'hFF, 5'h00, 1'b1, 1'b0, 1'b0, 3'd0);
    step(1'b1, 8'hFF, 5'h00, 1'b1, 1'b0, 1'b1, 3'd0);
    step(1'b1, 8'hFF, 5'h00, 1'b1, 1'b0, 1'b1, 3'd1);
    step(1'b1, 8'hFF, 5'h00, 1'b0, 1'b0, 1'b1, 3'd1);

    // WIDTH=5: ends alternate, wrap at 5
    step(1'b1, 8'h00, 5'h11, 1'b1, 1'b1, 1'b1, 3'd0);
    step(1'b1, 8'h00, 5'h11, 1'b1, 1'b1, 1'b1, 3'd4);
    step(1'b1, 8'h00, 5'h11, 1'b1, 1'b1, 1'b1, 3'd0);
    step(1'b1, 8'h00, 5'h11, 1'b1, 1'b1, 1'b1, 3'd4);
    step(1'b1, 8'h00, 5'h00, 1'b1, 1'b1, 1'b0, 3'd4);
    // ptr left at 0 -> 0, then ptr=1 -> 4
    step(1'b1, 8'h00, 5'h11, 1'b1, 1'b1, 1'b1, 3'd0);
    step(1'b1, 8'h00, 5'h10, 1'b1, 1'b1, 1'b1, 3'd4);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h00, 5'h1F, 1'b1, 1'b1, 1'b1, 3'(i));
    step(1'b1, 8'h00, 5'h1F, 1'b1, 1'b1, 1'b1, 3'd0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 4'(sb.size()), 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
